inst_fetch: RTL and testbench
=============================

INST_FETCH -- requirements
Module: inst_fetch

Interface
REQ-001 SHALL provide parameter RESET_PC, default 32'h00000000, meaning the fetch address loaded at reset.
REQ-002 SHALL provide parameter PC_STEP, default 32'd4, meaning the byte increment per sequential fetch.
REQ-003 SHALL have port clk  input  1  rising-edge clock, single clock domain.
REQ-004 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port addr  output  32  byte address driven to the instruction ROM, which decodes addr[6:2].
REQ-006 SHALL have port Inst  input  32  instruction word returned combinationally by the ROM in the same cycle.
REQ-007 SHALL have port stall  input  1  decode-stage hold request.
REQ-008 SHALL have port br_taken  input  1  redirect request, one cycle pulse.
REQ-009 SHALL have port br_target  input  32  redirect byte address, sampled when br_taken=1.
REQ-010 SHALL have port if_inst  output  32  registered instruction to decode.
REQ-011 SHALL have port if_pc  output  32  registered address of if_inst.
REQ-012 SHALL have port if_valid  output  1  if_inst/if_pc hold a live instruction.
REQ-013 SHALL have port err  output  1  sticky misaligned-redirect flag.

Function
REQ-014 SHALL hold a 32-bit pc register and drive addr = pc combinationally.
REQ-015 SHALL implement states BOOT, RUN, HALT; BOOT lasts exactly one cycle after reset release, then RUN.
REQ-016 SHALL, in BOOT, fetch no instruction: pc unchanged, if_valid stays 0.
REQ-017 SHALL, in RUN with stall=0 and br_taken=0, on each edge load if_inst<=Inst, if_pc<=pc, if_valid<=1, pc<=pc+PC_STEP (1-cycle latency addr→if_inst).
REQ-018 SHALL, in RUN with stall=1 and br_taken=0, hold pc, if_inst, if_pc, if_valid unchanged.
REQ-019 SHALL, when br_taken=1 in RUN, load pc<=br_target and clear if_valid<=0 (flush) regardless of stall; br_taken has priority over stall.
REQ-020 SHALL deliver the first redirected instruction one cycle after the flush cycle (two edges after br_taken).
REQ-021 SHALL wrap pc modulo 2^32 (32'hFFFFFFFC + 4 → 32'h00000000) without error.
REQ-022 SHALL, in HALT, hold pc, clear if_valid, ignore stall and br_taken; exit only via rst.
REQ-023 SHALL keep err=0 in every state except HALT.

Reset
REQ-024 SHALL, while rst=1 asynchronously, force pc=RESET_PC, if_inst=0, if_pc=0, if_valid=0, err=0, state=BOOT.
REQ-025 SHALL abandon any pending stall or redirect on reset mid-operation; no partial update survives.

Configuration
REQ-026 SHALL compile alignment checking only when macro INST_FETCH_ALIGN_CHECK_EN is defined.
REQ-027 SHALL, with INST_FETCH_ALIGN_CHECK_EN defined, on br_taken=1 with br_target[1:0]≠0, not load pc, set err<=1, clear if_valid, enter HALT.
REQ-028 SHALL, without INST_FETCH_ALIGN_CHECK_EN, load pc<={br_target[31:2],2'b00}, never enter HALT, tie err=0.

Verification
REQ-029 SHALL cover: rst pulse mid-run → addr=0, if_valid=0, err=0 immediately; first if_valid=1 two edges after release with if_pc=0.
REQ-030 SHALL cover: free run with ROM program loaded → if_pc=8 carries if_inst=32'h3c020001, if_pc=12 carries 32'h10220000, consecutive cycles.
REQ-031 SHALL cover: stall=1 for 3 cycles at if_pc=16 → if_inst=32'h00221824 and addr=20 held 3 cycles, sequence resumes at if_pc=20.
REQ-032 SHALL cover: br_taken=1, br_target=32'h2C, with stall=1 same cycle → next cycle if_valid=0, addr=2C; following cycle if_pc=2C, if_inst=32'h10240003.
REQ-033 SHALL cover: pc forced near top via br_target=32'hFFFFFFFC → next sequential addr=0, err=0.
REQ-034 SHALL cover: br_target=32'h2E → with macro err=1, HALT, addr frozen; without macro addr=2C, err=0.

Source files
------------

// File: rtl/inst_fetch.sv
// Instruction fetch stage: PC register, BOOT/RUN/HALT control and IF/ID pipeline register.
// Optional misaligned-redirect trap compiled in with INST_FETCH_ALIGN_CHECK_EN.
module inst_fetch #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] PC_STEP  = 32'd4
) (
    input  logic        clk,
    input  logic        rst,
    output logic [31:0] addr,
    input  logic [31:0] Inst,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_valid,
    output logic        err
);

    localparam logic [1:0] ST_BOOT = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_HALT = 2'd2;

    logic [1:0]  r_state;
    logic [31:0] r_pc;
    logic [31:0] r_ifInst;
    logic [31:0] r_ifPc;
    logic        r_ifValid;

    logic [1:0]  w_stateNext;
    logic [31:0] w_pcNext;
    logic [31:0] w_ifInstNext;
    logic [31:0] w_ifPcNext;
    logic        w_ifValidNext;
    logic        w_misaligned;
    logic [31:0] w_brAligned;
    logic        w_trap;

    // Low two target bits are dropped so a redirect always lands on a word boundary.
    assign w_brAligned = br_target & 32'hFFFF_FFFC;

`ifdef INST_FETCH_ALIGN_CHECK_EN
    assign w_misaligned = |br_target[1:0];
`else
    assign w_misaligned = 1'b0;
`endif

    assign w_trap = (r_state == ST_RUN) && br_taken && w_misaligned;

    always_comb begin
        w_stateNext   = r_state;
        w_pcNext      = r_pc;
        w_ifInstNext  = r_ifInst;
        w_ifPcNext    = r_ifPc;
        w_ifValidNext = r_ifValid;
        case (r_state)
            ST_BOOT: begin
                w_stateNext = ST_RUN;
            end
            ST_RUN: begin
                // A redirect flushes the IF/ID register and wins over a stall.
                if (br_taken) begin
                    w_ifValidNext = 1'b0;
                    if (w_misaligned) begin
                        w_stateNext = ST_HALT;
                    end else begin
                        w_pcNext = w_brAligned;
                    end
                end else if (!stall) begin
                    w_ifInstNext  = Inst;
                    w_ifPcNext    = r_pc;
                    w_ifValidNext = 1'b1;
                    w_pcNext      = r_pc + PC_STEP;
                end
            end
            ST_HALT: begin
                w_ifValidNext = 1'b0;
            end
            default: begin
                w_stateNext   = ST_BOOT;
                w_ifValidNext = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= ST_BOOT;
            r_pc      <= RESET_PC;
            r_ifInst  <= 32'h0;
            r_ifPc    <= 32'h0;
            r_ifValid <= 1'b0;
        end else begin
            r_state   <= w_stateNext;
            r_pc      <= w_pcNext;
            r_ifInst  <= w_ifInstNext;
            r_ifPc    <= w_ifPcNext;
            r_ifValid <= w_ifValidNext;
        end
    end

`ifdef INST_FETCH_ALIGN_CHECK_EN
    logic r_err;

    // Sticky until reset; only a trapped redirect can raise it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_err <= 1'b0;
        end else if (w_trap) begin
            r_err <= 1'b1;
        end
    end

    assign err = r_err;
`else
    logic w_trapUnused;
    assign w_trapUnused = w_trap;
    assign err          = 1'b0;
`endif

    assign addr     = r_pc;
    assign if_inst  = r_ifInst;
    assign if_pc    = r_ifPc;
    assign if_valid = r_ifValid;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch with a combinational ROM, a fetch scoreboard and constant checkpoints.
module tb_inst_fetch;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] inst;
   } fetch_t;

   logic        clk;
   logic        rst;
   logic [31:0] addr;
   logic [31:0] Inst;
   logic        stall;
   logic        br_taken;
   logic [31:0] br_target;
   logic [31:0] if_inst;
   logic [31:0] if_pc;
   logic        if_valid;
   logic        err;

   logic [31:0] rom [32];
   fetch_t      sbQueue [$];
   logic [31:0] mPc;
   logic        mValid;
   bit          mBoot;
   bit          mHalt;
   int          checks = 0;
   int          errors = 0;

   inst_fetch dut (
      .clk       (clk),
      .rst       (rst),
      .addr      (addr),
      .Inst      (Inst),
      .stall     (stall),
      .br_taken  (br_taken),
      .br_target (br_target),
      .if_inst   (if_inst),
      .if_pc     (if_pc),
      .if_valid  (if_valid),
      .err       (err)
   );

   // 10 ns clock; the ROM answers combinationally from addr[6:2]
   initial clk = 1'b0;
   always #5 clk = ~clk;
   assign Inst = rom[addr[6:2]];

   task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic check1(input string tag, input logic obs, input logic exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%b expected=%b", tag, obs, exp);
      end
   endtask

   // Compares the DUT against the bench's own fetch model after each edge
   task automatic checkOutput(input bit fetched);
      fetch_t expd;
      check32("addr", addr, mPc);
      check1("if_valid", if_valid, mValid);
      check1("err", err, mHalt);
      if (fetched) begin
         checks++;
         assert (sbQueue.size() > 0) else begin
            errors++;
            $error("[TB] FAIL scoreboard_empty: observed=0 expected=1");
         end
         if (sbQueue.size() > 0) begin
            expd = sbQueue.pop_front();
            check32("sb_if_pc", if_pc, expd.pc);
            check32("sb_if_inst", if_inst, expd.inst);
         end
      end
   endtask

   // Drives one cycle of stimulus, advances the model, then samples 1 ns after the edge
   task automatic applyStimulus(input logic s, input logic b, input logic [31:0] t);
      bit     fetched;
      fetch_t entry;
      stall     = s;
      br_taken  = b;
      br_target = t;
      fetched   = !mBoot && !mHalt && !b && !s;
      if (fetched) begin
         entry.pc   = mPc;
         entry.inst = rom[mPc[6:2]];
         sbQueue.push_back(entry);
         mPc    = mPc + 32'd4;
         mValid = 1'b1;
      end else if (!mBoot && !mHalt && b) begin
         mValid = 1'b0;
`ifdef INST_FETCH_ALIGN_CHECK_EN
         if (t[1:0] != 2'b00) mHalt = 1'b1;
         else                 mPc   = {t[31:2], 2'b00};
`else
         mPc = {t[31:2], 2'b00};
`endif
      end else if (mHalt) begin
         mValid = 1'b0;
      end
      mBoot = 1'b0;
      @(posedge clk);
      #1;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'h0;
      checkOutput(fetched);
   endtask

   task automatic resetModel();
      mPc    = 32'h0;
      mValid = 1'b0;
      mBoot  = 1'b1;
      mHalt  = 1'b0;
      sbQueue.delete();
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rom[i] = 32'hA500_0000 + i;
      rom[2]  = 32'h3c02_0001;
      rom[3]  = 32'h1022_0000;
      rom[4]  = 32'h0022_1824;
      rom[11] = 32'h1024_0003;

      rst       = 1'b1;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'h0;
      resetModel();
      #2;
      check32("rst_addr", addr, 32'h0);
      check32("rst_if_inst", if_inst, 32'h0);
      check32("rst_if_pc", if_pc, 32'h0);
      check1("rst_if_valid", if_valid, 1'b0);
      check1("rst_err", err, 1'b0);

      @(negedge clk);
      rst = 1'b0;
      applyStimulus(1'b0, 1'b0, 32'h0);
      check1("boot_no_fetch", if_valid, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      check32("first_if_pc", if_pc, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      check32("pc8_inst", if_inst, 32'h3c02_0001);
      applyStimulus(1'b0, 1'b0, 32'h0);
      check32("pc12_inst", if_inst, 32'h1022_0000);
      applyStimulus(1'b0, 1'b0, 32'h0);
      check32("pc16_inst", if_inst, 32'h0022_1824);

      for (int k = 0; k < 3; k++) begin
         applyStimulus(1'b1, 1'b0, 32'h0);
         check32("stall_inst", if_inst, 32'h0022_1824);
         check32("stall_if_pc", if_pc, 32'd16);
         check32("stall_addr", addr, 32'd20);
      end
      applyStimulus(1'b0, 1'b0, 32'h0);
      check32("resume_if_pc", if_pc, 32'd20);

      applyStimulus(1'b1, 1'b1, 32'h2C);
      check1("flush_valid", if_valid, 1'b0);
      check32("flush_addr", addr, 32'h2C);
      applyStimulus(1'b0, 1'b0, 32'h0);
      check32("redir_if_pc", if_pc, 32'h2C);
      check32("redir_inst", if_inst, 32'h1024_0003);

      applyStimulus(1'b0, 1'b1, 32'hFFFF_FFFC);
      check32("top_addr", addr, 32'hFFFF_FFFC);
      applyStimulus(1'b0, 1'b0, 32'h0);
      check32("wrap_addr", addr, 32'h0);
      check1("wrap_err", err, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      check32("post_wrap_addr", addr, 32'h4);

      applyStimulus(1'b0, 1'b1, 32'h2E);
`ifdef INST_FETCH_ALIGN_CHECK_EN
      check1("misalign_err", err, 1'b1);
      check32("misalign_addr", addr, 32'h4);
      applyStimulus(1'b0, 1'b0, 32'h0);
      applyStimulus(1'b1, 1'b1, 32'h40);
      check32("halt_addr", addr, 32'h4);
      check1("halt_valid", if_valid, 1'b0);
      check1("halt_err", err, 1'b1);
`else
      check32("misalign_addr", addr, 32'h2C);
      check1("misalign_err", err, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      check32("misalign_if_pc", if_pc, 32'h2C);
`endif

      // Pending stall and redirect are in flight when reset hits mid-cycle
      stall     = 1'b1;
      br_taken  = 1'b1;
      br_target = 32'h2C;
      #2;
      rst = 1'b1;
      #1;
      check32("midrst_addr", addr, 32'h0);
      check1("midrst_valid", if_valid, 1'b0);
      check1("midrst_err", err, 1'b0);
      check32("midrst_if_pc", if_pc, 32'h0);
      @(posedge clk);
      @(negedge clk);
      rst       = 1'b0;
      stall     = 1'b0;
      br_taken  = 1'b0;
      br_target = 32'h0;
      resetModel();
      applyStimulus(1'b0, 1'b0, 32'h0);
      check1("reboot_valid", if_valid, 1'b0);
      applyStimulus(1'b0, 1'b0, 32'h0);
      check1("refetch_valid", if_valid, 1'b1);
      check32("refetch_if_pc", if_pc, 32'h0);
      applyStimulus(1'b0, 1'b0, 32'h0);

      checks++;
      assert (sbQueue.size() == 0) else begin
         errors++;
         $error("[TB] FAIL sb_drain: observed=%0d expected=0", sbQueue.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
